// File: rtl/cmp_pkg.sv
// Shared types for the compare-result collector: FSM states, sample classes
// and the (Gt, Ls) classifier.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CLS_EQ  = 2'd0,
      CLS_GT  = 2'd1,
      CLS_LS  = 2'd2,
      CLS_ILL = 2'd3
   } cls_e;

   // Gt and Ls together cannot come from a sane compare stage, so that pair is illegal.
   function automatic cls_e classify(input logic gt, input logic ls);
      case ({gt, ls})
         2'b10:   return CLS_GT;
         2'b01:   return CLS_LS;
         2'b11:   return CLS_ILL;
         default: return CLS_EQ;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] q
);

   logic [CW-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr)
         q_d = '0;
      else if (inc && (q_q != {CW{1'b1}}))
         q_d = q_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/cmp_result_collector.sv
// Windowed classifier/counter for compare-stage results with a valid/ready report.
// Optional macro CMP_EARLY_STOP_EN: an error/illegal sample closes the window early.
module cmp_result_collector
   import cmp_pkg::*;
#(
   parameter int WINDOW = 4,
   parameter int CW     = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          Gt,
   input  logic          Ls,
   input  logic          Error,
   output logic          rpt_valid,
   input  logic          rpt_ready,
   output logic [CW-1:0] gt_cnt,
   output logic [CW-1:0] ls_cnt,
   output logic [CW-1:0] eq_cnt,
   output logic [CW-1:0] err_cnt,
   output logic          err_flag,
   output logic          rpt_early
);

   localparam int SW = $clog2(WINDOW + 1);

   state_e        state_q, state_d;
   logic [SW-1:0] smp_q, smp_d;
   logic          err_flag_q, err_flag_d;
   cls_e          cls;
   logic          accept, open_win, smp_err, last;

   assign cls      = classify(Gt, Ls);
   assign accept   = in_valid & (state_q == COLLECT);
   assign open_win = start & (state_q == IDLE);
   assign smp_err  = Error | (cls == CLS_ILL);

`ifdef CMP_EARLY_STOP_EN
   assign last = accept & ((smp_q == SW'(WINDOW - 1)) | smp_err);
`else
   assign last = accept & (smp_q == SW'(WINDOW - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)     state_d = COLLECT;
         COLLECT: if (last)      state_d = REPORT;
         REPORT:  if (rpt_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == COLLECT);
      rpt_valid = (state_q == REPORT);
   end

   // Sample counter only advances on handshakes and never exceeds WINDOW.
   always_comb begin
      smp_d      = smp_q;
      err_flag_d = err_flag_q;
      if (open_win) begin
         smp_d      = '0;
         err_flag_d = 1'b0;
      end else if (accept) begin
         smp_d = smp_q + 1'b1;
         if (smp_err) err_flag_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         smp_q      <= '0;
         err_flag_q <= 1'b0;
      end else begin
         smp_q      <= smp_d;
         err_flag_q <= err_flag_d;
      end
   end

   assign err_flag = err_flag_q;

`ifdef CMP_EARLY_STOP_EN
   logic early_q, early_d;

   always_comb begin
      early_d = early_q;
      if (open_win)
         early_d = 1'b0;
      else if (accept && smp_err && (smp_q != SW'(WINDOW - 1)))
         early_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) early_q <= 1'b0;
      else     early_q <= early_d;
   end

   assign rpt_early = early_q;
`else
   assign rpt_early = 1'b0;
`endif

   sat_counter #(.CW(CW)) u_gt (
      .clk(clk), .rst(rst), .clr(open_win),
      .inc(accept & (cls == CLS_GT)), .q(gt_cnt)
   );

   sat_counter #(.CW(CW)) u_ls (
      .clk(clk), .rst(rst), .clr(open_win),
      .inc(accept & (cls == CLS_LS)), .q(ls_cnt)
   );

   sat_counter #(.CW(CW)) u_eq (
      .clk(clk), .rst(rst), .clr(open_win),
      .inc(accept & (cls == CLS_EQ)), .q(eq_cnt)
   );

   sat_counter #(.CW(CW)) u_err (
      .clk(clk), .rst(rst), .clr(open_win),
      .inc(accept & smp_err), .q(err_cnt)
   );

endmodule
